// File: rtl/sw_cond.sv
// Switch conditioner: 2-flop sync, shared-counter debounce, committed image + change handshake.
// Optional single-step strobe on debounced SW0 rise is built only when SWCOND_STEP_EN is defined.
module sw_cond #(
  parameter int DEB_CNT = 1_000_000,
  parameter int CNT_W   = 20
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] SWI,
  output logic [15:0] sw_stable,
  output logic [2:0]  mode,
  output logic [4:0]  sw13t8,
  output logic [2:0]  sw765,
  output logic [1:0]  sw43,
  output logic        sw2,
  output logic        sw1,
  output logic        sw0,
  output logic        chg_valid,
  output logic [15:0] chg_mask,
  input  logic        chg_ack,
  output logic        step_pulse
);

  typedef enum logic {IDLE, SETTLE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

  logic [15:0]      sync1, sync2;
  state_t           state_q, state_d;
  logic [15:0]      cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             commit;
  logic [15:0]      diff;
  logic             chg_valid_d;
  logic [15:0]      chg_mask_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= SWI;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any movement while settling restarts the shared window; a return to the
  // committed value drops back to IDLE without committing.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2 != sw_stable) begin
          cand_d  = sync2;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (sync2 != cand_q) begin
          cand_d = sync2;
          cnt_d  = '0;
          if (sync2 == sw_stable) state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          commit  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign diff = cand_q ^ sw_stable;

  // A commit coinciding with an ack starts a fresh mask: the old one counts as delivered.
  always_comb begin
    chg_valid_d = chg_valid;
    chg_mask_d  = chg_mask;
    if (commit) begin
      chg_valid_d = 1'b1;
      chg_mask_d  = (chg_valid && !chg_ack) ? (chg_mask | diff) : diff;
    end else if (chg_valid && chg_ack) begin
      chg_valid_d = 1'b0;
      chg_mask_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sw_stable <= '0;
      chg_valid <= 1'b0;
      chg_mask  <= '0;
    end else begin
      if (commit) sw_stable <= cand_q;
      chg_valid <= chg_valid_d;
      chg_mask  <= chg_mask_d;
    end
  end

`ifdef SWCOND_STEP_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) step_pulse <= 1'b0;
    else       step_pulse <= commit && cand_q[0] && !sw_stable[0];
  end
`else
  assign step_pulse = 1'b0;
`endif

  assign mode   = sw_stable[15:13];
  assign sw13t8 = sw_stable[12:8];
  assign sw765  = sw_stable[7:5];
  assign sw43   = sw_stable[4:3];
  assign sw2    = sw_stable[2];
  assign sw1    = sw_stable[1];
  assign sw0    = sw_stable[0];

endmodule

// File: doc/sw_cond.md
# sw_cond

Switch-input conditioner and change scheduler for the 16 board slide switches. Synchronizes the raw switch bus, debounces it with one shared settle counter, and commits a stable 16-bit image plus the decoded control fields that the rest of the design uses (mode bits, field selects, clock/step bits). Each committed change is reported to downstream consumers through a valid/ack handshake with an accumulated change mask. It sits between the board switch pins and the lab top level, ahead of any field split-out.

## Interface
- DEB_CNT, 1_000_000 — cycles the synchronized input must hold before it is committed (10 ms at 100 MHz); legal range 1 to 2^CNT_W.
- CNT_W, 20 — settle-counter width.

- clk  in  1  — system clock.
- rstn  in  1  — reset. One clock; reset is asynchronous and active-low.
- SWI  in  16  — raw switch pins, asynchronous.
- sw_stable  out  16  — committed debounced switch image.
- mode  out  3  — sw_stable[15:13].
- sw13t8  out  5  — sw_stable[12:8].
- sw765  out  3  — sw_stable[7:5].
- sw43  out  2  — sw_stable[4:3].
- sw2, sw1, sw0  out  1 each  — sw_stable[2], [1], [0].
- chg_valid  out  1  — one or more commits pending acknowledgement.
- chg_mask  out  16  — bits changed since the last acknowledge.
- chg_ack  in  1  — consumer accepts the pending change.
- step_pulse  out  1  — single-step strobe (see Configuration).

## Operation
- Synchronizer: two flops, sync1 <= SWI, sync2 <= sync1. Only sync2 is used downstream.
- FSM state IDLE: if sync2 != sw_stable, then cand <= sync2, cnt <= 0, go to SETTLE.
- FSM state SETTLE, priority order:
  - If sync2 != cand: cand <= sync2, cnt <= 0. If sync2 == sw_stable, go to IDLE with no commit (glitch rejected).
  - Else if cnt == DEB_CNT-1: commit. sw_stable <= cand, diff = cand ^ sw_stable, go to IDLE.
  - Else cnt <= cnt+1.
- The field outputs are pure wires from sw_stable.
- Change handshake, evaluated each edge:
  - Commit with no pending change: chg_valid <= 1, chg_mask <= diff.
  - Commit while chg_valid=1 and chg_ack=0: chg_mask <= chg_mask | diff.
  - Commit in the same cycle as chg_valid & chg_ack: chg_valid stays 1, chg_mask <= diff. The old mask is considered delivered.
  - chg_valid & chg_ack with no commit: chg_valid <= 0, chg_mask <= 0.
  - chg_ack while chg_valid=0 is ignored.
- All 16 switches share one counter. Any bit moving during SETTLE restarts the settle window for all bits.

## Timing
- Reset values: sync1, sync2, cand, sw_stable, all fields, chg_valid, chg_mask, step_pulse = 0; cnt = 0; FSM = IDLE.
- Reset is asynchronous. Asserting it mid-SETTLE discards the candidate. After release, switches already on are committed as a normal change from all-zeros.
- Latency: SWI changes before edge e0. sync2 updates at e1, SETTLE is entered at e2, and the commit occurs at edge e0+DEB_CNT+2. sw_stable, chg_valid and chg_mask update on that same edge.
- With DEB_CNT=1: the commit lands at e3.
- chg_valid clears on the edge after chg_ack is sampled high, unless the same-cycle commit rule applies.
- Outputs are registered. There is no combinational path from SWI or chg_ack to any output.

## Configuration
- SWCOND_STEP_EN defined:
  - step_pulse is registered high for exactly one cycle, on the commit edge where cand[0]=1 and the old sw_stable[0]=0 (debounced rising edge of switch 0).
  - It drives the single-step clock enable.
  - A falling edge or a commit with bit 0 unchanged gives no pulse.
- SWCOND_STEP_EN undefined: step_pulse is tied to 0 and its logic is not built.

## Test plan
- Reset then steady input (DEB_CNT=4, SWI=16'h0000): all outputs 0, chg_valid never rises.
- Clean change (SWI=16'hA005 at e0): at e6, sw_stable=16'hA005, mode=3'b101, sw0=1, sw2=1, chg_valid=1, chg_mask=16'hA005. Then chg_ack=1 for one cycle clears chg_valid and chg_mask on the next edge.
- Bounce (bit 4 toggles 0→1→0→1 on alternate cycles, then holds): no commit until 4 full cycles of stable sync2. A pulse shorter than DEB_CNT that returns to the old value gives no commit and no chg_valid.
- Accumulate and same-cycle (commit bit 1 and hold ack low, then commit bit 9): chg_mask=16'h0202. Next, ack on the same cycle as a commit of bit 3: chg_valid stays 1, chg_mask=16'h0008.
- Async reset mid-SETTLE (rstn low for 2 ns between edges): all outputs 0 immediately, FSM IDLE. After release, a held SWI=16'h0100 commits at DEB_CNT+2 edges.
- SWCOND_STEP_EN (toggle SW0 0→1→0, each held 10 cycles): exactly one step_pulse, one cycle wide, on the rising commit edge. With the macro undefined, step_pulse stays 0.
